// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: default widths and FSM state encoding.
package prog_loader_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_NIB_W  = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HI   = 3'd1;
  localparam logic [2:0] ST_LO   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    HI   = ST_HI,
    LO   = ST_LO,
    WR   = ST_WR,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/load_addr_ctr.sv
// Program-memory write address and byte counter for the loader.
module load_addr_ctr #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count,
  output logic              at_max
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr  <= '0;
      count <= '0;
    end else if (clr) begin
      addr  <= '0;
      count <= '0;
    end else begin
      if (inc)  count <= count + COUNT_ONE;
      if (step) addr  <= addr + ADDR_ONE;
    end
  end

  assign at_max = &addr;

endmodule

// File: rtl/prog_loader.sv
// Loads program bytes from a nibble valid/ready link into program memory, holding the uP in reset meanwhile.
//   state | meaning
//   IDLE  | after reset; uP runs existing memory, waiting for start
//   HI    | waiting for high nibble of the next byte
//   LO    | waiting for low nibble (and nib_last)
//   WR    | one-cycle memory write strobe
//   DONE  | load finished or memory full; waiting for start
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NIB_W  = DEF_NIB_W,
  parameter int DATA_W = 2*NIB_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              nib_valid,
  input  logic [NIB_W-1:0]  nib_data,
  input  logic              nib_last,
  output logic              nib_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
);

  state_t state, state_next;

  logic [NIB_W-1:0] hi_q, lo_q;
  logic             last_q;
  logic             hi_en, lo_en;
  logic             ctr_clr, cnt_inc, addr_step, ovf_set;
  logic             at_max;

  load_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clock  (clock),
    .reset  (reset),
    .clr    (ctr_clr),
    .inc    (cnt_inc),
    .step   (addr_step),
    .addr   (mem_addr),
    .count  (byte_count),
    .at_max (at_max)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      last_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (hi_en) hi_q <= nib_data;
      if (lo_en) begin
        lo_q   <= nib_data;
        last_q <= nib_last;
      end
      if (ctr_clr)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    hi_en      = 1'b0;
    lo_en      = 1'b0;
    ctr_clr    = 1'b0;
    cnt_inc    = 1'b0;
    addr_step  = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          ctr_clr    = 1'b1;
          state_next = HI;
        end
      end
      HI: begin
        if (nib_valid) begin
          hi_en      = 1'b1;
          state_next = LO;
        end
      end
      LO: begin
        if (nib_valid) begin
          lo_en      = 1'b1;
          state_next = WR;
        end
      end
      WR: begin
        cnt_inc = 1'b1;
        if (last_q) begin
          state_next = DONE;
        end else if (at_max) begin
          // Memory full without nib_last: stop at the top address rather than wrap.
          ovf_set    = 1'b1;
          state_next = DONE;
        end else begin
          addr_step  = 1'b1;
          state_next = HI;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign nib_ready = (state == HI) || (state == LO);
  assign mem_we    = (state == WR);
  assign mem_wdata = {hi_q, lo_q};
  assign busy      = (state == HI) || (state == LO) || (state == WR);
  assign cpu_hold  = busy;
  assign done      = (state == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed loads, expected writes queued, monitor compares strobes.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        nib_valid = 1'b0;
  logic [3:0]  nib_data = 4'h0;
  logic        nib_last = 1'b0;
  logic        nib_ready, mem_we, cpu_hold, busy, done, overflow;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [12:0] byte_count;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int exp_addr = 0;
  logic [19:0] exp_q[$];
  int we_times[$];
  logic [19:0] mon_e;

  prog_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .nib_valid  (nib_valid),
    .nib_data   (nib_data),
    .nib_last   (nib_last),
    .nib_ready  (nib_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  // Monitor: every write strobe must match the head of the expected-write queue.
  always @(negedge clock) begin
    if (mem_we) begin
      we_times.push_back(cycle);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected got addr=%h data=%h, none expected", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_e) begin
          miscompares++;
          $display("FAIL write got addr=%h data=%h, want addr=%h data=%h",
                   mem_addr, mem_wdata, mon_e[19:8], mon_e[7:0]);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s timed out waiting on DUT", name);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic send_nib(input logic [3:0] d, input logic last, input int gap);
    int n;
    nib_valid = 1'b0;
    repeat (gap) @(negedge clock);
    nib_valid = 1'b1;
    nib_data  = d;
    nib_last  = last;
    n = 0;
    while (!nib_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!nib_ready) timeout_fail("nib_ready");
    else begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    exp_q.push_back({exp_addr[11:0], b});
    exp_addr++;
    send_nib(b[7:4], 1'b0, gap);
    send_nib(b[3:0], last, gap);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    nib_valid = 1'b0;
    nib_last  = 1'b0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("done", int'(done), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cpu_hold"}, int'(cpu_hold), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_mem_we"}, int'(mem_we), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    check({tag, "_byte_count"}, int'(byte_count), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_nib_ready"}, int'(nib_ready), 0);
  endtask

  initial begin
    logic [7:0] b;
    // reset state
    #12;
    check_idle_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 1: single byte with nib_last
    do_start();
    check("t1_cpu_hold", int'(cpu_hold), 1);
    check("t1_busy", int'(busy), 1);
    send_byte(8'h4A, 1'b1, 0);
    wait_done();
    check("t1_byte_count", int'(byte_count), 1);
    check("t1_cpu_hold_after", int'(cpu_hold), 0);
    check("t1_busy_after", int'(busy), 0);
    check("t1_overflow", int'(overflow), 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: back-to-back three-byte stream, strobes 3 cycles apart
    we_times.delete();
    do_start();
    check("t2_done_cleared", int'(done), 0);
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    send_byte(8'h56, 1'b1, 0);
    wait_done();
    check("t2_byte_count", int'(byte_count), 3);
    check("t2_we_count", we_times.size(), 3);
    if (we_times.size() == 3) begin
      check("t2_spacing_01", we_times[1] - we_times[0], 3);
      check("t2_spacing_12", we_times[2] - we_times[1], 3);
    end
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: nib_last on a high nibble is ignored
    do_start();
    exp_q.push_back({12'h000, 8'hC3});
    send_nib(4'hC, 1'b1, 0);
    send_nib(4'h3, 1'b0, 0);
    @(negedge clock);
    check("t3_not_done", int'(done), 0);
    check("t3_busy", int'(busy), 1);
    exp_q.push_back({12'h001, 8'h7E});
    send_nib(4'h7, 1'b1, 0);
    send_nib(4'hE, 1'b1, 0);
    wait_done();
    check("t3_byte_count", int'(byte_count), 2);
    check("t3_sb_empty", exp_q.size(), 0);

    // 4: fill all 4096 locations without nib_last
    do_start();
    for (int i = 0; i < 4096; i++) begin
      b = i[7:0] ^ 8'h5A;
      send_byte(b, 1'b0, 0);
    end
    wait_done();
    check("t4_overflow", int'(overflow), 1);
    check("t4_byte_count", int'(byte_count), 4096);
    check("t4_nib_ready", int'(nib_ready), 0);
    check("t4_addr_no_wrap", int'(mem_addr), 12'hFFF);
    check("t4_cpu_hold", int'(cpu_hold), 0);
    check("t4_sb_empty", exp_q.size(), 0);
    do_start();
    check("t4_overflow_cleared", int'(overflow), 0);

    // 5: asynchronous reset after high nibble of byte 2
    send_byte(8'h9B, 1'b0, 0);
    send_nib(4'hD, 1'b0, 0);
    nib_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    @(negedge clock);
    @(negedge clock);
    check("t5_no_write", int'(mem_we), 0);
    reset = 1'b1;
    @(negedge clock);
    check("t5_sb_empty", exp_q.size(), 0);
    do_start();
    send_byte(8'hE1, 1'b1, 0);
    wait_done();
    check("t5_byte_count", int'(byte_count), 1);
    check("t5_sb_empty2", exp_q.size(), 0);

    // 6: random valid gaps, start pulsed mid-load
    do_start();
    for (int i = 0; i < 8; i++) begin
      b = 8'h30 + 8'(i * 7);
      if (i == 3) start = 1'b1;
      send_byte(b, i == 7, int'($urandom_range(0, 3)));
      start = 1'b0;
      if (i == 3) check("t6_busy_after_start", int'(busy), 1);
    end
    wait_done();
    check("t6_byte_count", int'(byte_count), 8);
    check("t6_overflow", int'(overflow), 0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
